instruction_fetch_queue: RTL and testbench
==========================================

// Module: instruction_fetch_queue
// PURPOSE
//  PC generator + prefetch FIFO; upstream of the single-cycle decode/controller stage.
//  Issues word fetches to instruction memory over a req/ack + response handshake.
//  Buffers up to DEPTH fetched words and presents {Instruction, NextInstruct} with valid/ready.
//  Applies branch/jump redirects from decode: flush queue, discard in-flight response, refetch.
// PARAMETERS
//  DEPTH     4             prefetch FIFO entries; power of 2, 2..16
//  RESET_PC  32'h00000000  byte address of first fetch after reset
// PORTS
//  Clk           in   1   rising-edge clock
//  Reset         in   1   synchronous, active-low reset
//  IMemReq       out  1   fetch request valid
//  IMemAddr      out  32  fetch byte address, word aligned ([1:0]=0)
//  IMemAck       in   1   request accepted this cycle (IMemReq && IMemAck = issue)
//  IMemRspValid  in   1   response word valid; at least 1 cycle after issue
//  IMemRspData   in   32  fetched instruction word
//  InstValid     out  1   head entry valid
//  InstReady     in   1   decode consumes head (InstValid && InstReady = accept)
//  Instruction   out  32  head instruction word
//  NextInstruct  out  32  head PC + 4 (link value for JAL)
//  BranchTaken   in   1   head resolves as taken branch; sampled on accept only
//  BranchOffset  in   32  sign-extended imm16; target = NextInstruct + (BranchOffset << 2)
//  Jump          in   1   head is jump; sampled on accept only; priority over BranchTaken
//  JumpTarget    in   32  absolute byte target for Jump (J/JAL/JR already resolved)
// BEHAVIOUR
//  Reset (Reset==0 at edge): FetchPC=RESET_PC, FIFO empty, state RUN, no outstanding request;
//   IMemReq=0, InstValid=0, Instruction=0, NextInstruct=0 from next cycle. Reset mid-fetch drops the response.
//  States: RUN (may issue), WAIT (1 outstanding, await IMemRspValid), DROP (await stale rsp, discard).
//  Max one outstanding fetch. IMemReq=1 in RUN iff count < DEPTH; IMemAddr=FetchPC.
//   IMemReq/IMemAddr held stable until IMemAck. On issue: FetchPC+=4, RUN->WAIT.
//  WAIT: on IMemRspValid push {IMemRspData, pc_of_req+4}; ->RUN. Push and pop may coincide.
//   Count never exceeds DEPTH: issue gated on count==DEPTH; pop same cycle does not unblock issue.
//  Head: InstValid=(count!=0); Instruction/NextInstruct from FIFO head, combinational from storage.
//   Bypass-free: response word appears on InstValid at earliest 1 cycle after IMemRspValid.
//  Redirect = accept && (Jump || BranchTaken). Target = Jump ? JumpTarget : NextInstruct+(BranchOffset<<2),
//   32-bit wrap, bits[1:0] forced 0. Next cycle: FIFO empty, FetchPC=target.
//   Redirect in WAIT with rsp not this cycle -> DROP; rsp same cycle as redirect is discarded, -> RUN.
//   DROP: IMemReq=0; on IMemRspValid discard, -> RUN. Redirect wins over concurrent push.
//  Redirect with an un-acked request pending: request withdrawn; next cycle IMemAddr=target.
//  FetchPC wraps 32'hFFFFFFFC -> 0. IMemRspValid in RUN with nothing outstanding: ignored.
//  Instruction==0 (NOP) is queued/returned like any other word.
// CONFIGURATION
//  IFQ_PERF_COUNT_EN defined: adds out ports FlushCount[31:0] (+1 per redirect) and
//   StallCount[31:0] (+1 per cycle InstReady && !InstValid); both saturate at 32'hFFFFFFFF, cleared by Reset.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset then mem acks every cycle, 1-cycle rsp, InstReady=1 -> Instruction stream PCs 0,4,8..; NextInstruct=4,8,12.
//  InstReady=0, DEPTH=4 -> exactly 4 issues, IMemReq=0 with count=4; resume -> no word lost or duplicated.
//  Accept at NextInstruct=32'h10, BranchTaken=1, BranchOffset=-2 -> next IMemAddr=32'h08, queue flushed.
//  Jump=1,JumpTarget=32'h400 while fetch outstanding, rsp 3 cycles later -> rsp discarded, next IMemAddr=32'h400.
//  Jump and BranchTaken both 1 -> JumpTarget used; Reset=0 mid-WAIT -> IMemAddr=RESET_PC, late rsp dropped.
//  RESET_PC=32'hFFFFFFF8 -> fetches FFFFFFF8, FFFFFFFC, 00000000; NextInstruct of last = 4.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - PC generator and prefetch FIFO feeding the decode stage
// Optional feature macro: IFQ_PERF_COUNT_EN (adds FlushCount/StallCount ports).
module instruction_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic        IMemRspValid,
   input  logic [31:0] IMemRspData,
   output logic        InstValid,
   input  logic        InstReady,
   output logic [31:0] Instruction,
   output logic [31:0] NextInstruct,
   input  logic        BranchTaken,
   input  logic [31:0] BranchOffset,
   input  logic        Jump,
   input  logic [31:0] JumpTarget
`ifdef IFQ_PERF_COUNT_EN
   ,
   output logic [31:0] FlushCount,
   output logic [31:0] StallCount
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   logic [1:0]    state;
   logic          started;
   logic [31:0]   fetch_pc;
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   npc_mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          issue;
   logic          accept;
   logic          redirect;
   logic          push;
   logic [31:0]   target;

   // started keeps the request low for the whole cycle that follows a reset edge
   assign IMemReq      = started && (state == ST_RUN) && (count < FULL);
   assign IMemAddr     = fetch_pc;
   assign InstValid    = (count != '0);
   assign Instruction  = InstValid ? data_mem[rd_ptr] : '0;
   assign NextInstruct = InstValid ? npc_mem[rd_ptr] : '0;

   assign issue    = IMemReq && IMemAck;
   assign accept   = InstValid && InstReady;
   assign redirect = accept && (Jump || BranchTaken);
   assign push     = (state == ST_WAIT) && IMemRspValid && !redirect;
   assign target   = (Jump ? JumpTarget : (NextInstruct + (BranchOffset << 2))) & 32'hFFFF_FFFC;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state    <= ST_RUN;
         started  <= 1'b0;
         fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         started <= 1'b1;
         if (redirect) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= target;
         end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (accept) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(accept);
         end
         case (state)
            ST_RUN:  if (issue) state <= redirect ? ST_DROP : ST_WAIT;
            ST_WAIT: begin
               if (IMemRspValid) state <= ST_RUN;
               else if (redirect) state <= ST_DROP;
            end
            ST_DROP: if (IMemRspValid) state <= ST_RUN;
            default: state <= ST_RUN;
         endcase
      end
   end

   // While waiting, fetch_pc already equals the outstanding request's PC + 4
   always_ff @(posedge Clk) begin
      if (Reset && push) begin
         data_mem[wr_ptr] <= IMemRspData;
         npc_mem[wr_ptr]  <= fetch_pc;
      end
   end

`ifdef IFQ_PERF_COUNT_EN
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         FlushCount <= '0;
         StallCount <= '0;
      end else begin
         if (redirect && (FlushCount != 32'hFFFF_FFFF)) FlushCount <= FlushCount + 32'd1;
         if (InstReady && !InstValid && (StallCount != 32'hFFFF_FFFF)) StallCount <= StallCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - randomized bench with queue-level reference model
module tb_instruction_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck = 1'b0;
   logic        IMemRspValid = 1'b0;
   logic [31:0] IMemRspData = '0;
   logic        InstValid;
   logic        InstReady = 1'b0;
   logic [31:0] Instruction;
   logic [31:0] NextInstruct;
   logic        BranchTaken = 1'b0;
   logic [31:0] BranchOffset = '0;
   logic        Jump = 1'b0;
   logic [31:0] JumpTarget = '0;
`ifdef IFQ_PERF_COUNT_EN
   logic [31:0] FlushCount;
   logic [31:0] StallCount;
`endif

   instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .Clk(Clk), .Reset(Reset),
      .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
      .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData),
      .InstValid(InstValid), .InstReady(InstReady),
      .Instruction(Instruction), .NextInstruct(NextInstruct),
      .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
      .Jump(Jump), .JumpTarget(JumpTarget)
`ifdef IFQ_PERF_COUNT_EN
      , .FlushCount(FlushCount), .StallCount(StallCount)
`endif
   );

   initial forever #5 Clk = ~Clk;

   typedef struct {
      logic [31:0] data;
      logic [31:0] npc;
   } ent_t;

   // reference model: queued words, fetch PC, live/stale outstanding fetch
   ent_t        q[$];
   logic [31:0] m_pc = RESET_PC;
   logic [31:0] m_out_addr = '0;
   bit          m_out, m_stale, m_started;

   int checks = 0;
   int errors = 0;

   bit c_rst, c_branch_at, c_jump_out;
   int c_ack, c_rdy, c_dly_min, c_dly_max, c_spur, c_redir;

   bit          mem_pend;
   logic [31:0] mem_addr;
   int          mem_cnt;

   bit          w_issue, w_acc;
   logic [31:0] got_issue, got_acc;
   logic [31:0] issue_log[$];
   logic [31:0] acc_log[$];
   int          n_issue;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[5:2] == 4'd3) return 32'd0;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic bit pct(input int p);
      return int'($urandom_range(0, 99)) < p;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      bit rsp, ack, rdy, jmp, bt, e_req, issue, accept, redir;
      logic [31:0] rdata, jt, off, tgt;
      if (w_issue && IMemReq) begin
         got_issue = IMemAddr;
         w_issue = 0;
      end
      rsp = 0;
      rdata = $urandom;
      if (mem_pend) begin
         if (mem_cnt == 0) begin
            rsp = 1;
            rdata = mem_word(mem_addr);
            mem_pend = 0;
         end else mem_cnt--;
      end else if (pct(c_spur)) rsp = 1;
      ack = c_rst && !mem_pend && pct(c_ack);
      rdy = pct(c_rdy);
      jmp = 0;
      bt = 0;
      jt = $urandom;
      off = 32'($urandom_range(0, 2047)) - 32'd1024;
      if (pct(c_redir)) begin
         jmp = 1'($urandom_range(0, 1));
         bt  = 1'($urandom_range(0, 1));
      end
      if (c_branch_at && q.size() != 0 && q[0].npc == 32'h10) begin
         rdy = 1; jmp = 0; bt = 1; off = 32'hFFFF_FFFE; c_branch_at = 0;
      end
      if (c_jump_out && q.size() != 0 && m_out) begin
         rdy = 1; jmp = 1; bt = 1; jt = 32'h400; off = 32'h40; c_jump_out = 0;
      end
      if (w_acc && c_rst && InstValid && rdy) begin
         got_acc = NextInstruct;
         w_acc = 0;
      end
      Reset = c_rst; IMemAck = ack; IMemRspValid = rsp; IMemRspData = rdata;
      InstReady = rdy; Jump = jmp; BranchTaken = bt; JumpTarget = jt; BranchOffset = off;
      if (IMemReq && ack) begin
         mem_pend = 1;
         mem_addr = IMemAddr;
         mem_cnt = int'($urandom_range(c_dly_min, c_dly_max));
         n_issue++;
         issue_log.push_back(IMemAddr);
      end
      if (c_rst && InstValid && rdy) acc_log.push_back(NextInstruct);

      if (!c_rst) begin
         q.delete(); m_pc = RESET_PC; m_out = 0; m_stale = 0; m_started = 0;
      end else begin
         e_req  = m_started && !m_out && !m_stale && q.size() < DEPTH;
         issue  = e_req && ack;
         accept = q.size() != 0 && rdy;
         redir  = accept && (jmp || bt);
         if (redir) begin
            tgt = jmp ? jt : q[0].npc + (off << 2);
            tgt[1:0] = 2'b00;
            m_stale = issue || ((m_out || m_stale) && !rsp);
            m_out = 0;
            q.delete();
            m_pc = tgt;
            w_issue = 1;
            w_acc = 1;
         end else begin
            if (accept) void'(q.pop_front());
            if (m_out && rsp) begin
               q.push_back('{data: mem_word(m_out_addr), npc: m_out_addr + 32'd4});
               m_out = 0;
            end
            if (m_stale && rsp) m_stale = 0;
            if (issue) begin
               m_out = 1;
               m_out_addr = m_pc;
               m_pc = m_pc + 32'd4;
            end
         end
         m_started = 1;
      end

      @(posedge Clk);
      #1;
      e_req = m_started && !m_out && !m_stale && q.size() < DEPTH;
      chk("imem_req", 32'(IMemReq), 32'(e_req));
      if (e_req) chk("imem_addr", IMemAddr, m_pc);
      chk("inst_valid", 32'(InstValid), 32'(q.size() != 0));
      chk("instruction", Instruction, (q.size() != 0) ? q[0].data : 32'd0);
      chk("next_instruct", NextInstruct, (q.size() != 0) ? q[0].npc : 32'd0);
   endtask

   task automatic do_reset();
      c_rst = 0;
      step();
      step();
      c_rst = 1;
      issue_log.delete();
      acc_log.delete();
      n_issue = 0;
      w_issue = 0;
      w_acc = 0;
   endtask

   initial begin
      c_ack = 100; c_rdy = 100; c_dly_min = 0; c_dly_max = 0; c_spur = 0; c_redir = 0;
      c_branch_at = 0; c_jump_out = 0;

      do_reset();
      chk("reset_req", 32'(IMemReq), 32'd0);
      chk("reset_valid", 32'(InstValid), 32'd0);
      chk("reset_instruction", Instruction, 32'd0);
      chk("reset_next_instruct", NextInstruct, 32'd0);
      repeat (12) step();
      while (issue_log.size() < 3) issue_log.push_back('x);
      while (acc_log.size() < 3) acc_log.push_back('x);
      chk("stream_addr0", issue_log[0], 32'hFFFF_FFF8);
      chk("stream_addr1", issue_log[1], 32'hFFFF_FFFC);
      chk("stream_addr2", issue_log[2], 32'h0000_0000);
      chk("stream_npc0", acc_log[0], 32'hFFFF_FFFC);
      chk("stream_npc1", acc_log[1], 32'h0000_0000);
      chk("stream_npc2", acc_log[2], 32'h0000_0004);

      do_reset();
      c_rdy = 0;
      repeat (20) step();
      chk("stall_issues", 32'(n_issue), 32'd4);
      chk("stall_req_low", 32'(IMemReq), 32'd0);
      chk("stall_valid", 32'(InstValid), 32'd1);
      c_rdy = 100;
      c_branch_at = 1;
      got_issue = 32'hDEAD_BEEF;
      got_acc = 32'hDEAD_BEEF;
      repeat (30) step();
      chk("branch_target", got_issue, 32'h0000_0008);
      chk("branch_first_npc", got_acc, 32'h0000_000C);

      do_reset();
      c_rdy = 0; c_dly_min = 2; c_dly_max = 2;
      c_jump_out = 1;
      got_issue = 32'hDEAD_BEEF;
      got_acc = 32'hDEAD_BEEF;
      for (int i = 0; i < 40 && c_jump_out; i++) step();
      c_rdy = 100;
      repeat (20) step();
      chk("jump_target", got_issue, 32'h0000_0400);
      chk("jump_first_npc", got_acc, 32'h0000_0404);

      for (int i = 0; i < 20 && !m_out; i++) step();
      c_rst = 0;
      step();
      c_rst = 1;
      w_issue = 1; w_acc = 1;
      got_issue = 32'hDEAD_BEEF;
      got_acc = 32'hDEAD_BEEF;
      repeat (25) step();
      chk("midwait_reset_addr", got_issue, RESET_PC);
      chk("midwait_reset_npc", got_acc, 32'hFFFF_FFFC);

      do_reset();
      c_ack = 70; c_rdy = 60; c_dly_min = 0; c_dly_max = 3; c_spur = 5; c_redir = 10;
      for (int i = 0; i < 4000; i++) begin
         c_rst = ($urandom_range(0, 199) != 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
